iobus_uart_tx: RTL and testbench
================================

# iobus_uart_tx

Memory-mapped UART transmitter that answers the processor's IOBUS. It decodes writes on IOBUS_ADDR/IOBUS_OUT/IOBUS_WR, queues bytes in a small FIFO and serializes them 8-N-1 on TX. It returns a status word on IOBUS_IN for polling loads. It sits beside the OTTER core in the top-level, with IOBUS_IN OR-combined with other peripherals.

## Interface
- CLKS_PER_BIT, 868: clock cycles per serial bit (100 MHz / 115200); must be ≥ 2.
- FIFO_DEPTH, 8: byte entries; power of two, ≥ 2.
- BASE_ADDR, 32'h1100_00C0: DATA register address; STATUS is at BASE_ADDR+4.
- CLK  in  1  system clock; all state changes on posedge.
- RST  in  1  synchronous, active-high reset.
- IOBUS_ADDR  in  32  processor IO address.
- IOBUS_OUT  in  32  processor write data.
- IOBUS_WR  in  1  processor write strobe, one cycle per store.
- IOBUS_IN  out  32  read data to processor; combinational.
- TX  out  1  serial line; idles high.
- BUSY  out  1  high while a frame is on the line or the FIFO is non-empty.

## Operation
- Clock and reset: one clock (CLK); reset is synchronous and active-high (RST).
- DATA write:
  - IOBUS_WR=1 with IOBUS_ADDR==BASE_ADDR pushes IOBUS_OUT[7:0]; upper bits are ignored.
  - The push is accepted if count<FIFO_DEPTH, or if a pop happens in the same cycle.
  - Otherwise the byte is dropped and sticky OVF is set.
- STATUS write: IOBUS_WR=1 at BASE_ADDR+4 with IOBUS_OUT[3]=1 clears OVF. Other bits are ignored.
- Reads are combinational on IOBUS_ADDR, with no side effects:
  - BASE_ADDR+4 returns {16'b0, count[7:0], 4'b0, OVF, tx_active, full, empty}.
  - BASE_ADDR returns 32'b0.
  - Any other address returns 32'b0, which keeps the OR-combine safe.
- Transmit FSM states are IDLE, START, DATA, STOP.
  - IDLE: TX=1. If FIFO non-empty, pop into shift register and go to START.
  - START: TX=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: TX=shift[0], LSB first, CLKS_PER_BIT cycles per bit; shift right each bit. After bit 7, go to STOP.
  - STOP: TX=1 for CLKS_PER_BIT cycles. At the end, if FIFO non-empty, pop and go directly to START (no idle gap); else go to IDLE.
- Pop timing: a pop occurs only on the IDLE→START or STOP→START transition.
- Counters:
  - Baud counter is $clog2(CLKS_PER_BIT) bits, reloads at 0 on every state or bit transition.
  - Bit index is 3 bits.
  - FIFO count is $clog2(FIFO_DEPTH)+1 bits.
  - FIFO pointers wrap modulo FIFO_DEPTH.
- Reset, including mid-frame:
  - FSM goes to IDLE, TX=1, FIFO is emptied, OVF=0, counters=0.
  - The partial frame is abandoned.

## Timing
- Reset values: TX=1, BUSY=0, IOBUS_IN=0 for non-STATUS addresses, STATUS reads 32'h0000_0001.
- TX is registered.
- Write at edge N into an empty idle block:
  - count=1 after N.
  - Pop at edge N+1; TX falls after N+1.
- Start bit begins 1 cycle after the write edge.
- Frame length is exactly 10·CLKS_PER_BIT cycles.
- Back-to-back frames are contiguous: the stop bit is followed immediately by the next start bit.
- BUSY = tx_active | !empty.
  - It is registered-derived: it rises after the write edge and falls after the final stop-bit cycle.
- Status reflects state after the most recent edge; a read in the same cycle as a write sees the pre-write count.

## Structure
- Shared package uart_pkg holds:
  - typedef enum tx_state_t {IDLE, START, DATA, STOP};
  - register offsets DATA_OFS=0, STAT_OFS=4;
  - status bit indices.
- Sub-module sync_fifo(WIDTH=8, DEPTH) provides push/pop/full/empty/count with a registered read pointer.
  - Its read data is valid in the same cycle as pop.
- Top module holds the address decode, OVF, FSM, baud/bit counters and shift register.

## Test plan
- Reset and single byte:
  - Stimulus: CLKS_PER_BIT=4; reset, then write 32'hFFFF_FF55 to BASE_ADDR.
  - TX after the write edge: 0 for 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then 1 for 4 cycles.
  - BUSY falls at cycle 40.
- Back-to-back:
  - Stimulus: write 8'hA5 then 8'h3C on consecutive cycles.
  - Second start bit begins exactly 40 cycles after the first; there is no idle high cycle between frames.
- Overflow:
  - Stimulus: FIFO_DEPTH=8, 10 writes on consecutive cycles to an idle block.
  - First byte pops; 8 are queued (full=1); the 10th is dropped, giving OVF=1 and STATUS bit3=1.
  - Writing 32'h8 to BASE_ADDR+4 clears OVF.
- Push with same-cycle pop when full:
  - Stimulus: FIFO full and STOP ending in the same cycle as a DATA write.
  - Write is accepted, count stays 8, OVF stays 0.
- Reset mid-frame:
  - Stimulus: assert RST during DATA bit 3 with 3 bytes queued.
  - TX=1 the next cycle, STATUS=32'h1, and no further frames are sent.
- Read decode:
  - IOBUS_ADDR=BASE_ADDR+8 returns 32'h0.
  - BASE_ADDR+4 with 2 queued bytes while transmitting returns 32'h0000_0204.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and register map for the IOBUS UART transmitter.
// Register offsets are relative to the block's base address.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam logic [31:0] DATA_OFS = 32'd0;
    localparam logic [31:0] STAT_OFS = 32'd4;

    // Bit positions within the STATUS word; count occupies [15:8].
    localparam int ST_EMPTY  = 0;
    localparam int ST_FULL   = 1;
    localparam int ST_ACTIVE = 2;
    localparam int ST_OVF    = 3;
    localparam int ST_COUNT  = 8;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO, show-ahead read: pop_dat is valid in the cycle pop is asserted.
// A push when full is accepted only if a pop happens in the same cycle; otherwise it is ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_dat,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_dat,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign pop_dat = mem[rd_ptr];

    // When full, wr_ptr equals rd_ptr; the old entry is read combinationally before the edge overwrites it.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/iobus_uart_tx.sv
// Memory-mapped 8-N-1 UART transmitter on the IOBUS; start bit begins one cycle after the DATA write.
// No stalls: a DATA write into a full FIFO (without a same-cycle pop) is dropped and sets sticky OVF.
module iobus_uart_tx
    import uart_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 868,
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [31:0] BASE_ADDR    = 32'h1100_00C0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] IOBUS_ADDR,
    input  logic [31:0] IOBUS_OUT,
    input  logic        IOBUS_WR,
    output logic [31:0] IOBUS_IN,
    output logic        TX,
    output logic        BUSY
);
    localparam int          BW        = $clog2(CLKS_PER_BIT);
    localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [31:0] DATA_ADDR = BASE_ADDR + DATA_OFS;
    localparam logic [31:0] STAT_ADDR = BASE_ADDR + STAT_OFS;

    tx_state_t     state, state_nxt;
    logic [BW-1:0] baud, baud_nxt;
    logic [2:0]    bit_idx, bit_nxt;
    logic [7:0]    shift, shift_nxt;
    logic          tx_nxt;
    logic          baud_end;
    logic          tx_active;
    logic          ovf;

    logic          data_wr;
    logic          stat_wr;
    logic          fifo_pop;
    logic [7:0]    fifo_dat;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          unused_bits;

    assign data_wr     = IOBUS_WR && (IOBUS_ADDR == DATA_ADDR);
    assign stat_wr     = IOBUS_WR && (IOBUS_ADDR == STAT_ADDR);
    assign unused_bits = ^IOBUS_OUT[31:8];

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (CLK),
        .rst      (RST),
        .push     (data_wr),
        .push_dat (IOBUS_OUT[7:0]),
        .pop      (fifo_pop),
        .pop_dat  (fifo_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign baud_end  = (baud == BAUD_LAST);
    assign tx_active = (state != IDLE);
    assign BUSY      = tx_active || !fifo_empty;

    always_comb begin
        state_nxt = state;
        baud_nxt  = baud + 1'b1;
        bit_nxt   = bit_idx;
        shift_nxt = shift;
        fifo_pop  = 1'b0;
        case (state)
            IDLE: begin
                baud_nxt = '0;
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    shift_nxt = fifo_dat;
                    state_nxt = START;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_nxt  = '0;
                    bit_nxt   = 3'd0;
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_nxt = '0;
                    if (bit_idx == 3'd7) begin
                        state_nxt = STOP;
                    end else begin
                        bit_nxt   = bit_idx + 3'd1;
                        shift_nxt = shift >> 1;
                    end
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_nxt = '0;
                    // Chain straight into the next start bit so frames stay contiguous.
                    if (!fifo_empty) begin
                        fifo_pop  = 1'b1;
                        shift_nxt = fifo_dat;
                        state_nxt = START;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        case (state_nxt)
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = shift_nxt[0];
            default: tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            TX      <= 1'b1;
        end else begin
            state   <= state_nxt;
            baud    <= baud_nxt;
            bit_idx <= bit_nxt;
            shift   <= shift_nxt;
            TX      <= tx_nxt;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ovf <= 1'b0;
        end else if (data_wr && fifo_full && !fifo_pop) begin
            ovf <= 1'b1;
        end else if (stat_wr && IOBUS_OUT[ST_OVF]) begin
            ovf <= 1'b0;
        end
    end

    always_comb begin
        IOBUS_IN = 32'b0;
        if (IOBUS_ADDR == STAT_ADDR) begin
            IOBUS_IN[ST_COUNT +: 8] = 8'(fifo_count);
            IOBUS_IN[ST_OVF]        = ovf;
            IOBUS_IN[ST_ACTIVE]     = tx_active;
            IOBUS_IN[ST_FULL]       = fifo_full;
            IOBUS_IN[ST_EMPTY]      = fifo_empty;
        end
    end

endmodule

// File: tb/tb_iobus_uart_tx.sv
// Directed bench for iobus_uart_tx at 4 clocks per bit and an 8-entry FIFO.
// k counts negedges after the first write edge of each step.
module tb_iobus_uart_tx;
    localparam int          CPB   = 4;
    localparam int          DEPTH = 8;
    localparam logic [31:0] BASE  = 32'h1100_00C0;
    localparam logic [31:0] STAT  = BASE + 32'd4;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] IOBUS_ADDR;
    logic [31:0] IOBUS_OUT;
    logic        IOBUS_WR;
    logic [31:0] IOBUS_IN;
    logic        TX;
    logic        BUSY;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] rd_val;

    iobus_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .BASE_ADDR    (BASE)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .IOBUS_ADDR (IOBUS_ADDR),
        .IOBUS_OUT  (IOBUS_OUT),
        .IOBUS_WR   (IOBUS_WR),
        .IOBUS_IN   (IOBUS_IN),
        .TX         (TX),
        .BUSY       (BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic tick;
        @(negedge CLK);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        IOBUS_ADDR = a;
        #1;
        d = IOBUS_IN;
    endtask

    // Drives one store across the next posedge; returns at the following negedge.
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        IOBUS_ADDR = a;
        IOBUS_OUT  = d;
        IOBUS_WR   = 1'b1;
        tick();
        IOBUS_WR   = 1'b0;
    endtask

    // Expected line level k cycles after the first write edge, for nf back-to-back frames.
    function automatic logic exp_line(input logic [7:0] b0, input logic [7:0] b1,
                                      input int nf, input int k);
        int         p;
        logic [7:0] b;
        if (k < 1 || k > 40 * nf) return 1'b1;
        p = (k - 1) % 40;
        b = ((k - 1) / 40 == 0) ? b0 : b1;
        if (p < 4)  return 1'b0;
        if (p < 36) return b[(p - 4) / 4];
        return 1'b1;
    endfunction

    initial begin
        RST        = 1'b1;
        IOBUS_ADDR = 32'h0;
        IOBUS_OUT  = 32'h0;
        IOBUS_WR   = 1'b0;
        tick();
        tick();
        RST = 1'b0;
        tick();

        // Reset state
        chk("rst_tx", 32'(TX), 32'h1);
        chk("rst_busy", 32'(BUSY), 32'h0);
        rd(STAT, rd_val);
        chk("rst_status", rd_val, 32'h0000_0001);
        rd(BASE, rd_val);
        chk("rst_data_rd", rd_val, 32'h0);

        // Single byte 0x55; upper write bits ignored
        wr(BASE, 32'hFFFF_FF55);
        chk("t1_tx_k0", 32'(TX), 32'h1);
        chk("t1_busy_k0", 32'(BUSY), 32'h1);
        rd(STAT, rd_val);
        chk("t1_status_k0", rd_val, 32'h0000_0100);
        for (int k = 1; k <= 41; k++) begin
            tick();
            chk($sformatf("t1_tx_k%0d", k), 32'(TX), 32'(exp_line(8'h55, 8'h00, 1, k)));
            if (k == 2) begin
                rd(STAT, rd_val);
                chk("t1_status_k2", rd_val, 32'h0000_0005);
            end
            if (k == 40) chk("t1_busy_k40", 32'(BUSY), 32'h1);
            if (k == 41) chk("t1_busy_k41", 32'(BUSY), 32'h0);
        end

        // Back-to-back 0xA5, 0x3C: no idle cycle between frames
        wr(BASE, 32'h0000_00A5);
        wr(BASE, 32'h0000_003C);
        rd(STAT, rd_val);
        chk("t2_status_k1", rd_val, 32'h0000_0104);
        chk("t2_tx_k1", 32'(TX), 32'h0);
        for (int k = 2; k <= 81; k++) begin
            tick();
            chk($sformatf("t2_tx_k%0d", k), 32'(TX), 32'(exp_line(8'hA5, 8'h3C, 2, k)));
            if (k == 80) chk("t2_busy_k80", 32'(BUSY), 32'h1);
            if (k == 81) chk("t2_busy_k81", 32'(BUSY), 32'h0);
        end

        // Overflow: 10 consecutive writes, first pops, 8 queue, 10th dropped
        for (int i = 0; i < 10; i++) begin
            wr(BASE, 32'h10 + 32'(i));
        end
        rd(STAT, rd_val);
        chk("t3_status_ovf", rd_val, 32'h0000_080E);
        wr(STAT, 32'h0000_0008);
        rd(STAT, rd_val);
        chk("t3_status_clr", rd_val, 32'h0000_0806);

        // Full FIFO, write lands on the edge where STOP ends and pops
        for (int k = 11; k <= 40; k++) begin
            tick();
        end
        chk("t4_tx_stop_k40", 32'(TX), 32'h1);
        wr(BASE, 32'h0000_0077);
        rd(STAT, rd_val);
        chk("t4_status_k41", rd_val, 32'h0000_0806);
        chk("t4_tx_k41", 32'(TX), 32'h0);

        // Reset with a frame in flight and a full FIFO
        RST = 1'b1;
        tick();
        RST = 1'b0;
        rd(STAT, rd_val);
        chk("t5_status_rst", rd_val, 32'h0000_0001);
        chk("t5_tx_rst", 32'(TX), 32'h1);

        // Reset mid-frame during DATA bit 3 with 3 bytes queued
        wr(BASE, 32'h0000_00C3);
        wr(BASE, 32'h0000_0001);
        wr(BASE, 32'h0000_0002);
        wr(BASE, 32'h0000_0003);
        rd(STAT, rd_val);
        chk("t6_status_k3", rd_val, 32'h0000_0304);
        for (int k = 4; k <= 18; k++) begin
            tick();
        end
        chk("t6_tx_bit3", 32'(TX), 32'h0);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("t6_tx_after_rst", 32'(TX), 32'h1);
        chk("t6_busy_after_rst", 32'(BUSY), 32'h0);
        rd(STAT, rd_val);
        chk("t6_status_after_rst", rd_val, 32'h0000_0001);
        for (int k = 0; k < 50; k++) begin
            tick();
            chk($sformatf("t6_tx_quiet_%0d", k), 32'(TX), 32'h1);
        end
        chk("t6_busy_quiet", 32'(BUSY), 32'h0);

        // Read decode while transmitting with 2 queued bytes
        wr(BASE, 32'h0000_0011);
        wr(BASE, 32'h0000_0022);
        wr(BASE, 32'h0000_0033);
        rd(STAT, rd_val);
        chk("t7_status_k2", rd_val, 32'h0000_0204);
        rd(BASE + 32'd8, rd_val);
        chk("t7_rd_base8", rd_val, 32'h0);
        rd(BASE, rd_val);
        chk("t7_rd_data", rd_val, 32'h0);
        wr(BASE + 32'd8, 32'h0000_0044);
        rd(STAT, rd_val);
        chk("t7_status_nowr", rd_val, 32'h0000_0204);

        // Drain, bounded
        for (int k = 0; k < 200 && BUSY; k++) begin
            tick();
        end
        chk("t7_drained_busy", 32'(BUSY), 32'h0);
        rd(STAT, rd_val);
        chk("t7_drained_status", rd_val, 32'h0000_0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
